// File: rtl/hazard_stall_ctrl.sv
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl: ID-stage stall, flush and freeze control with counters. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             ifid_use_rs1_i,
  input  logic             ifid_use_rs2_i,
  input  logic             ifid_branch_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             idex_regwrite_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       exmem_rd_i,
  input  logic             exmem_memread_i,
  input  logic             icache_stall_i,
  input  logic             dcache_stall_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             ifid_flush_o,
  output logic             pipe_freeze_o,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] lu_stalls_o,
  output logic [CNT_W-1:0] br_stalls_o,
  output logic [CNT_W-1:0] frz_cycles_o
);

  localparam int LEN_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(TIMEOUT);
  localparam logic [LEN_W-1:0] LEN_TRIP = LEN_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] frz_len_q, frz_len_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] lu_cnt_q, br_cnt_q, frz_cnt_q;

  logic idex_hit, exmem_hit;
  logic frz, lu, br;
  logic lu_evt, br_evt;

  // A source matches only when it is actually read and is not x0.
  assign idex_hit  = (ifid_use_rs1_i && ifid_rs1_i != 5'd0 && ifid_rs1_i == idex_rd_i) ||
                     (ifid_use_rs2_i && ifid_rs2_i != 5'd0 && ifid_rs2_i == idex_rd_i);
  assign exmem_hit = (ifid_use_rs1_i && ifid_rs1_i != 5'd0 && ifid_rs1_i == exmem_rd_i) ||
                     (ifid_use_rs2_i && ifid_rs2_i != 5'd0 && ifid_rs2_i == exmem_rd_i);

  assign frz = icache_stall_i | dcache_stall_i;
  assign lu  = idex_memread_i & idex_hit;
  assign br  = ifid_branch_i & ((idex_regwrite_i & idex_hit) | (exmem_memread_i & exmem_hit));

  assign lu_evt = lu & ~frz;
  assign br_evt = br & ~lu & ~frz;

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_bubble_o = 1'b1;
    ifid_flush_o  = 1'b0;
    pipe_freeze_o = 1'b0;
    if (rst_n) begin
      if (frz) begin
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b1;
      end else if (!(lu || br)) begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = branch_taken_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    frz_len_d = frz_len_q;
    timeout_d = timeout_q | (frz && frz_len_q == LEN_TRIP);
    case (state_q)
      RUN: begin
        if (frz) begin
          state_d   = FREEZE;
          frz_len_d = LEN_W'(1);
        end
      end
      FREEZE: begin
        if (frz) begin
          if (frz_len_q != LEN_MAX) frz_len_d = frz_len_q + LEN_W'(1);
        end else begin
          state_d   = RUN;
          frz_len_d = '0;
        end
      end
      default: begin
        state_d   = RUN;
        frz_len_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      frz_len_q <= '0;
      timeout_q <= 1'b0;
      lu_cnt_q  <= '0;
      br_cnt_q  <= '0;
      frz_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      frz_len_q <= frz_len_d;
      timeout_q <= timeout_d;
      if (lu_evt && lu_cnt_q != '1)  lu_cnt_q  <= lu_cnt_q + CNT_W'(1);
      if (br_evt && br_cnt_q != '1)  br_cnt_q  <= br_cnt_q + CNT_W'(1);
      if (frz && frz_cnt_q != '1)    frz_cnt_q <= frz_cnt_q + CNT_W'(1);
    end
  end

  assign stall_timeout_o = timeout_q;
  assign lu_stalls_o     = lu_cnt_q;
  assign br_stalls_o     = br_cnt_q;
  assign frz_cycles_o    = frz_cnt_q;

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage RV32IC core. It is the stalling counterpart of the forwarding logic: it detects dependencies that forwarding cannot resolve, freezes the pipe on I-cache or D-cache misses, gates branch flushes, and counts stall cycles. The stall decisions are combinational, and the freeze tracking, watchdog and counters are sequential. It sits in the ID stage and drives the PC and the IF/ID and ID/EX register controls.

## Interface
- CNT_W, 16: width of each saturating performance counter.
- TIMEOUT, 1024: number of consecutive freeze cycles after which STALL_TIMEOUT sets.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IFID_RS1, IFID_RS2  in  5 each  source registers of the instruction in ID.
- IFID_USE_RS1, IFID_USE_RS2  in  1 each  the instruction in ID actually reads that source.
- IFID_BRANCH  in  1  the instruction in ID is a branch or JALR resolved in ID.
- BRANCH_TAKEN  in  1  ID branch or jump resolved taken.
- IDEX_RD  in  5  destination register in EX.
- IDEX_RegWrite, IDEX_MemRead  in  1 each  the instruction in EX writes rd / is a load.
- EXMEM_RD  in  5  destination register in MEM.
- EXMEM_MemRead  in  1  the instruction in MEM is a load.
- ICACHE_STALL, DCACHE_STALL  in  1 each  cache miss in progress.
- PC_WRITE  out  1  PC may update.
- IFID_WRITE  out  1  IF/ID register may load.
- IDEX_BUBBLE  out  1  load a NOP into ID/EX.
- IFID_FLUSH  out  1  clear IF/ID (squash the fetched instruction).
- PIPE_FREEZE  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
- STALL_TIMEOUT  out  1  sticky watchdog flag.
- LU_STALLS, BR_STALLS, FRZ_CYCLES  out  CNT_W each  saturating counters for load-use stall cycles, branch-dependency stall cycles and freeze cycles.

## Operation
- Register match: a register matches only when the register numbers are equal, the number is not x0, and the corresponding USE bit is set.
- FRZ = ICACHE_STALL | DCACHE_STALL.
- LU (load-use): IDEX_MemRead and IDEX_RD matches RS1 or RS2.
- BR (branch dependency): IFID_BRANCH and either
  - IDEX_RegWrite and IDEX_RD matches a source, or
  - EXMEM_MemRead and EXMEM_RD matches a source.
- A branch that depends on a load in EX therefore stalls 2 cycles: first via the IDEX term, then via the EXMEM term.
- Priority is FRZ > LU > BR > flush. Outputs by priority:
  - FRZ: PIPE_FREEZE=1, PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=0, IFID_FLUSH=0.
  - LU or BR: PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1, IFID_FLUSH=0, PIPE_FREEZE=0.
  - Otherwise: PC_WRITE=1, IFID_WRITE=1, IDEX_BUBBLE=0, PIPE_FREEZE=0, and IFID_FLUSH=BRANCH_TAKEN.
- BRANCH_TAKEN is ignored in any cycle with FRZ, LU or BR. The branch instruction is still held in ID, so it re-evaluates on a later cycle.
- When LU and BR are both true, the cycle counts only as LU.
- FSM states:
  - RUN: FRZ=1 moves to FREEZE and loads the freeze-length counter with 1.
  - FREEZE: FRZ=1 stays and increments the freeze-length counter (saturating at TIMEOUT). FRZ=0 returns to RUN and clears the counter.
- STALL_TIMEOUT sets on the edge where the freeze-length counter equals TIMEOUT-1 and FRZ is still 1. It clears only on reset.
- Counters advance by 1 on each clock edge where the matching condition is true. They saturate at all-ones and never wrap.

## Timing
- All stall, bubble, flush and freeze outputs are combinational from the current inputs, with zero latency. There are no registered outputs except STALL_TIMEOUT and the counters.
- The FSM and counters update on the rising edge. A count is visible the cycle after its event.
- Reset (rst_n low, asynchronous):
  - State goes to RUN; all counters and STALL_TIMEOUT clear to 0.
  - While reset is held: PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1, IFID_FLUSH=0, PIPE_FREEZE=0.
- Reset during FREEZE aborts the freeze immediately. After release, the first edge re-enters FREEZE if FRZ is still high.
- A 1-cycle cache stall gives exactly one freeze cycle, and FRZ_CYCLES increments by 1.
- Back-to-back ICACHE and DCACHE misses with no gap form one continuous FREEZE interval.

## Test plan
- Load-use: load x5 in EX, `add x6,x5,x1` in ID → exactly 1 cycle of PC_WRITE=0 with IDEX_BUBBLE=1, then normal flow; LU_STALLS=1.
- Branch after load: load x7 followed by `beq x7,x0` → BR asserts for 2 consecutive cycles (LU wins the first); then IFID_FLUSH=1 if taken; LU_STALLS=1, BR_STALLS=1.
- x0 and USE gating: `lw x0` followed by `add x1,x0,x0` → no stall. An instruction with IDEX_RD==RS2 but IFID_USE_RS2=0 → no stall.
- DCACHE_STALL held for 5 cycles while a load-use hazard and BRANCH_TAKEN are both present → PIPE_FREEZE=1 for 5 cycles with no bubble and no flush, then LU handling; FRZ_CYCLES=5.
- TIMEOUT=8 with ICACHE_STALL held for 10 cycles → STALL_TIMEOUT rises after the 8th freeze edge and stays high after the stall ends, until reset.
- Saturation: with CNT_W=4, apply 20 load-use stalls → LU_STALLS=15. Asserting rst_n low mid-freeze → all outputs take their reset values immediately.
